pipe_rca: RTL and testbench

PIPE_RCA -- requirements
Module: pipe_rca

---
 rtl/pipe_rca.sv | 168 ++++++++++++++++
 tb/tb_pipe_rca.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_rca.sv
// pipe_rca: first-order Boolean-masked ripple-carry adder, one pipeline stage
// per sum bit plus a final unmasking stage (latency W+1, throughput 1).
// Operands arrive as two shares (A = a0^a1, B = b0^b1). Every intermediate
// value stays split into two shares until the final stage. Carries use
// domain-oriented masked ANDs.
// Optional feature: define PIPE_RCA_LFSR_EN to draw the fresh mask bits from
// an internal 16-bit Galois LFSR. Otherwise the mask bits are tied to 0; the
// result is identical but the design is unprotected.
// Handshake: no backpressure. in_valid/operands are sampled on every rising
// edge. out_valid marks that sum holds the result of a valid input.
module pipe_rca #(
  parameter int          W         = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic [W:0]   sum,
  output logic         out_valid
);

  // two fresh mask bits per stage: [2k] for a&b, [2k+1] for p&cin
  logic [2*W-1:0] rnd;

`ifdef PIPE_RCA_LFSR_EN
  logic [15:0] lfsr_q;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, one step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // bits are distinct for W <= 8; wider adders reuse LFSR bits
  always_comb begin
    rnd = '0;
    for (int i = 0; i < 2*W; i++) rnd[i] = lfsr_q[i[3:0]];
  end
`else
  assign rnd = '0;
`endif

  // Stage registers. Operand shares are kept shifted right so that stage k
  // always consumes bit 0 of what it receives.
  logic [W-1:0] a0_q [W];
  logic [W-1:0] a1_q [W];
  logic [W-1:0] b0_q [W];
  logic [W-1:0] b1_q [W];
  logic [W-1:0] s0_q [W];
  logic [W-1:0] s1_q [W];
  // DOM partial products: gi/gx for a&b, ti/tx for p&cin (inner / cross)
  logic gi0_q [W];
  logic gi1_q [W];
  logic gx0_q [W];
  logic gx1_q [W];
  logic ti0_q [W];
  logic ti1_q [W];
  logic tx0_q [W];
  logic tx1_q [W];
  logic vld_q [W];

  // stage inputs and next-state values
  logic [W-1:0] ia0 [W];
  logic [W-1:0] ia1 [W];
  logic [W-1:0] ib0 [W];
  logic [W-1:0] ib1 [W];
  logic [W-1:0] is0 [W];
  logic [W-1:0] is1 [W];
  logic [W-1:0] ns0 [W];
  logic [W-1:0] ns1 [W];
  logic         ic0 [W];
  logic         ic1 [W];
  logic         iv  [W];
  logic         p0  [W];
  logic         p1  [W];
  logic         cw0;
  logic         cw1;

  // route shares into each stage and compress the previous stage's carry
  always_comb begin
    ia0[0] = a0;
    ia1[0] = a1;
    ib0[0] = b0;
    ib1[0] = b1;
    is0[0] = '0;
    is1[0] = '0;
    ic0[0] = 1'b0;
    ic1[0] = 1'b0;
    iv[0]  = in_valid;
    for (int k = 1; k < W; k++) begin
      ia0[k] = a0_q[k-1];
      ia1[k] = a1_q[k-1];
      ib0[k] = b0_q[k-1];
      ib1[k] = b1_q[k-1];
      is0[k] = s0_q[k-1];
      is1[k] = s1_q[k-1];
      ic0[k] = gi0_q[k-1] ^ gx0_q[k-1] ^ ti0_q[k-1] ^ tx0_q[k-1];
      ic1[k] = gi1_q[k-1] ^ gx1_q[k-1] ^ ti1_q[k-1] ^ tx1_q[k-1];
      iv[k]  = vld_q[k-1];
    end
    for (int k = 0; k < W; k++) begin
      p0[k]  = ia0[k][0] ^ ib0[k][0];
      p1[k]  = ia1[k][0] ^ ib1[k][0];
      // bit k of the sum shares is still zero here, so OR inserts it
      ns0[k] = is0[k] | (W'(p0[k] ^ ic0[k]) << k);
      ns1[k] = is1[k] | (W'(p1[k] ^ ic1[k]) << k);
    end
    cw0 = gi0_q[W-1] ^ gx0_q[W-1] ^ ti0_q[W-1] ^ tx0_q[W-1];
    cw1 = gi1_q[W-1] ^ gx1_q[W-1] ^ ti1_q[W-1] ^ tx1_q[W-1];
  end

  // per-bit stages: register sum shares and masked AND partial products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W; k++) begin
        a0_q[k]  <= '0;
        a1_q[k]  <= '0;
        b0_q[k]  <= '0;
        b1_q[k]  <= '0;
        s0_q[k]  <= '0;
        s1_q[k]  <= '0;
        gi0_q[k] <= 1'b0;
        gi1_q[k] <= 1'b0;
        gx0_q[k] <= 1'b0;
        gx1_q[k] <= 1'b0;
        ti0_q[k] <= 1'b0;
        ti1_q[k] <= 1'b0;
        tx0_q[k] <= 1'b0;
        tx1_q[k] <= 1'b0;
        vld_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < W; k++) begin
        a0_q[k]  <= ia0[k] >> 1;
        a1_q[k]  <= ia1[k] >> 1;
        b0_q[k]  <= ib0[k] >> 1;
        b1_q[k]  <= ib1[k] >> 1;
        s0_q[k]  <= ns0[k];
        s1_q[k]  <= ns1[k];
        gi0_q[k] <= ia0[k][0] & ib0[k][0];
        gi1_q[k] <= ia1[k][0] & ib1[k][0];
        gx0_q[k] <= (ia0[k][0] & ib1[k][0]) ^ rnd[2*k];
        gx1_q[k] <= (ia1[k][0] & ib0[k][0]) ^ rnd[2*k];
        ti0_q[k] <= p0[k] & ic0[k];
        ti1_q[k] <= p1[k] & ic1[k];
        tx0_q[k] <= (p0[k] & ic1[k]) ^ rnd[2*k+1];
        tx1_q[k] <= (p1[k] & ic0[k]) ^ rnd[2*k+1];
        vld_q[k] <= iv[k];
      end
    end
  end

  // final stage: recombine the shares into the plain result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      sum       <= {cw0 ^ cw1, s0_q[W-1] ^ s1_q[W-1]};
      out_valid <= vld_q[W-1];
    end
  end

endmodule

// File: tb/tb_pipe_rca.sv
// tb_pipe_rca: directed and randomized checks of pipe_rca against a plain
// arithmetic reference (sum = A + B, result W+1 cycles after sampling).
module tb_pipe_rca;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a0, a1, b0, b1;
  logic [W:0]   sum;
  logic         out_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [W:0] exp_q[$];
  logic       expv_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  pipe_rca #(.W(W), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .sum       (sum),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pipeline contents right after reset: W zero results with valid low
  task automatic prime();
    exp_q.delete();
    expv_q.delete();
    for (int i = 0; i < W; i++) begin
      exp_q.push_back('0);
      expv_q.push_back(1'b0);
    end
  endtask

  // drive one cycle of raw shares, then score the oldest pending result
  task automatic drive_raw(input logic v, input logic [W-1:0] x0, input logic [W-1:0] x1,
                           input logic [W-1:0] y0, input logic [W-1:0] y1, input string tag);
    logic [W:0] e;
    logic       ev;
    in_valid = v;
    a0 = x0;
    a1 = x1;
    b0 = y0;
    b1 = y1;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, x0 ^ x1} + {1'b0, y0 ^ y1});
    expv_q.push_back(v);
    e  = exp_q.pop_front();
    ev = expv_q.pop_front();
    check({tag, ".sum"}, sum, e);
    check({tag, ".valid"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, ev});
  endtask

  // drive plain operands A, B with a fresh random share split
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] ma, mb;
    ma = W'($urandom_range(0, (1 << W) - 1));
    mb = W'($urandom_range(0, (1 << W) - 1));
    drive_raw(v, ma, a ^ ma, mb, b ^ mb, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      drive(1'b0, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    #12;
    check("reset.sum", sum, '0);
    check("reset.valid", {{W{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prime();

    // single operand after reset: 0+6
    drive_raw(1'b1, 4'h1, 4'h1, 4'h2, 4'h4, "first");
    idle(W + 1, "first_drain");

    // full carry ripple: F + F
    drive_raw(1'b1, 4'h5, 4'hA, 4'h3, 4'hC, "ripple");
    idle(W + 1, "ripple_drain");

    // back-to-back operands
    drive(1'b1, 4'h3, 4'h4, "b2b0");
    drive(1'b1, 4'h8, 4'h8, "b2b1");
    drive(1'b1, 4'hF, 4'h1, "b2b2");
    drive(1'b1, 4'h0, 4'h0, "b2b3");
    idle(W + 1, "b2b_drain");

    // exhaustive operands, random shares
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(1'b1, W'(a), W'(b), "exh");

    // random valid pattern
    for (int i = 0; i < 40; i++)
      drive(1'(($urandom_range(0, 1))), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "rand");

    // no valid input: out_valid must stay low
    idle(12, "novalid");

    // reset two cycles after a valid input
    drive(1'b1, 4'h9, 4'h7, "mid_rst");
    drive(1'b0, 4'h0, 4'h0, "mid_rst");
    drive(1'b0, 4'h0, 4'h0, "mid_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.sum", sum, '0);
    check("async_rst.valid", {{W{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    check("held_rst.sum", sum, '0);
    check("held_rst.valid", {{W{1'b0}}, out_valid}, '0);
    rst = 1'b0;
    prime();
    for (int i = 0; i < 2 * W; i++) drive(1'b0, 4'h0, 4'h0, "post_rst");
    drive(1'b1, 4'h2, 4'h3, "post_rst_valid");
    idle(W + 1, "post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
